// File: rtl/instruction_loader.sv
// Boot loader: parses a byte-serial frame (SYNC, 20-bit address, word count,
// little-endian words, checksum) into instruction-memory writes; holds the core in reset while loading.
module instruction_loader #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter bit HOLD_AT_RESET  = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [19:0] instruction_wr,
  output logic [15:0] instruction_wr_data,
  output logic        instruction_wr_enable,
  output logic        core_reset,
  output logic        load_done,
  output logic        load_error,
  output logic [15:0] word_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [3:0] {IDLE, ADDR0, ADDR1, ADDR2, CNT0, CNT1, DLO, DHI, CHK} state_t;

  state_t        state;
  logic [19:0]   addr;
  logic [15:0]   remaining;
  logic [7:0]    lo;
  logic [7:0]    sum;
  logic [TW-1:0] tcnt;
  logic          accept;
  logic [7:0]    sum_next;

  assign accept   = rx_valid && rx_ready;
  assign sum_next = sum + rx_data;

  always_ff @(posedge clock) begin
    if (reset) begin
      state                 <= IDLE;
      rx_ready              <= 1'b0;
      instruction_wr        <= '0;
      instruction_wr_data   <= '0;
      instruction_wr_enable <= 1'b0;
      core_reset            <= HOLD_AT_RESET;
      load_done             <= 1'b0;
      load_error            <= 1'b0;
      word_count            <= '0;
      addr                  <= '0;
      remaining             <= '0;
      lo                    <= '0;
      sum                   <= '0;
      tcnt                  <= '0;
    end else begin
      rx_ready              <= 1'b1;
      instruction_wr_enable <= 1'b0;
      load_done             <= 1'b0;
      if (accept) begin
        tcnt <= '0;
        // every byte after SYNC, including CHK itself, feeds the running sum
        if (state != IDLE) sum <= sum_next;
        case (state)
          IDLE: if (rx_data == 8'hA5) begin
            state      <= ADDR0;
            core_reset <= 1'b1;
            load_error <= 1'b0;
            word_count <= '0;
            sum        <= '0;
          end
          ADDR0: begin addr[7:0]   <= rx_data;      state <= ADDR1; end
          ADDR1: begin addr[15:8]  <= rx_data;      state <= ADDR2; end
          ADDR2: begin addr[19:16] <= rx_data[3:0]; state <= CNT0;  end
          CNT0:  begin remaining[7:0] <= rx_data;   state <= CNT1;  end
          CNT1: begin
            remaining[15:8] <= rx_data;
            state <= ({rx_data, remaining[7:0]} != 16'd0) ? DLO : CHK;
          end
          DLO: begin lo <= rx_data; state <= DHI; end
          DHI: begin
            instruction_wr        <= addr;
            instruction_wr_data   <= {rx_data, lo};
            instruction_wr_enable <= 1'b1;
            word_count            <= word_count + 16'd1;
            addr                  <= addr + 20'd1;
            remaining             <= remaining - 16'd1;
            state <= (remaining != 16'd1) ? DLO : CHK;
          end
          CHK: begin
            state <= IDLE;
            if (sum_next == 8'h00) begin
              load_done  <= 1'b1;
              core_reset <= 1'b0;
            end else begin
              load_error <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
          load_error <= 1'b1;
          state      <= IDLE;
          tcnt       <= '0;
        end else begin
          tcnt <= tcnt + TW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Self-checking bench for instruction_loader: directed frames plus random frames
// checked against a frame-level parser model.
module tb_instruction_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [19:0] instruction_wr;
  logic [15:0] instruction_wr_data;
  logic        instruction_wr_enable;
  logic        core_reset;
  logic        load_done;
  logic        load_error;
  logic [15:0] word_count;

  int errors = 0;
  int checks = 0;

  logic [35:0] got_q[$];
  logic [35:0] exp_q[$];
  logic [7:0]  frm[$];
  int          done_cnt = 0;
  int          pulse_bad = 0;
  bit          en_prev = 1'b0;
  bit          exp_good;
  int          exp_n;

  always #5 clock = ~clock;

  instruction_loader #(.TIMEOUT_CYCLES(16), .HOLD_AT_RESET(1'b1)) dut (
    .clock(clock), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .instruction_wr(instruction_wr),
    .instruction_wr_data(instruction_wr_data), .instruction_wr_enable(instruction_wr_enable),
    .core_reset(core_reset), .load_done(load_done), .load_error(load_error),
    .word_count(word_count)
  );

  // Write/done monitor sampled on the falling edge
  always @(negedge clock) begin
    if (instruction_wr_enable) got_q.push_back({instruction_wr, instruction_wr_data});
    if (instruction_wr_enable && en_prev) pulse_bad++;
    if (load_done) done_cnt++;
    en_prev = instruction_wr_enable;
  end

  task automatic idle(input int n);
    rx_valid = 1'b0;
    for (int i = 0; i < n; i++) begin @(posedge clock); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    @(posedge clock); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input int maxgap);
    got_q.delete(); done_cnt = 0; pulse_bad = 0;
    foreach (frm[i]) begin
      if (maxgap > 0) idle($urandom_range(maxgap, 0));
      send_byte(frm[i]);
    end
  endtask

  // Frame-level reference: parse the byte list by the frame rules
  task automatic model();
    int a, n, s;
    exp_q.delete();
    a = int'(frm[1]) | (int'(frm[2]) << 8) | ((int'(frm[3]) & 15) << 16);
    n = int'(frm[4]) | (int'(frm[5]) << 8);
    s = 0;
    for (int k = 1; k < frm.size(); k++) s += int'(frm[k]);
    for (int i = 0; i < n; i++)
      exp_q.push_back({20'((a + i) % (1 << 20)), frm[7 + 2*i], frm[6 + 2*i]});
    exp_good = (s % 256) == 0;
    exp_n = n;
  endtask

  task automatic make_rand_frame(input bit good);
    int a, n, s;
    frm.delete();
    a = $urandom_range(20'hFFFFF, 0);
    if ($urandom_range(3, 0) == 0) a = 20'hFFFFE;
    n = $urandom_range(5, 0);
    frm.push_back(8'hA5);
    frm.push_back(8'(a));
    frm.push_back(8'(a >> 8));
    frm.push_back({4'($urandom_range(15, 0)), 4'(a >> 16)});
    frm.push_back(8'(n));
    frm.push_back(8'h00);
    repeat (2*n) frm.push_back(8'($urandom_range(255, 0)));
    s = 0;
    for (int k = 1; k < frm.size(); k++) s += int'(frm[k]);
    frm.push_back(8'(256 - (s % 256) + (good ? 0 : 1)));
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(3);
    checks++;
    if (rx_ready !== 1'b0) begin errors++; $display("FAIL reset_rx_ready got=%b exp=0", rx_ready); end
    checks++;
    if ({instruction_wr, instruction_wr_data, instruction_wr_enable} !== 37'd0) begin
      errors++; $display("FAIL reset_wr got=%h/%h/%b exp=0", instruction_wr, instruction_wr_data, instruction_wr_enable);
    end
    checks++;
    if ({core_reset, load_done, load_error, word_count} !== {1'b1, 1'b0, 1'b0, 16'd0}) begin
      errors++; $display("FAIL reset_status got cr=%b done=%b err=%b wc=%0d exp cr=1 rest 0", core_reset, load_done, load_error, word_count);
    end
    reset = 1'b0;
    idle(1);
    checks++;
    if (rx_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset got=%b exp=1", rx_ready); end
  endtask

  task automatic test_basic();
    frm = '{8'hA5, 8'h10, 8'h00, 8'h00, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'hDA};
    exp_q = '{{20'h00010, 16'h1234}, {20'h00011, 16'h5678}};
    send_frame(0);
    checks++;
    if ({load_done, core_reset} !== 2'b10) begin errors++; $display("FAIL basic_done_next got done=%b cr=%b exp 1/0", load_done, core_reset); end
    idle(2);
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_nwrites got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_write%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++;
    if ({done_cnt, pulse_bad, word_count, load_error, core_reset} !== {32'd1, 32'd0, 16'd2, 1'b0, 1'b0}) begin
      errors++; $display("FAIL basic_status got done=%0d pb=%0d wc=%0d err=%b cr=%b exp 1/0/2/0/0", done_cnt, pulse_bad, word_count, load_error, core_reset);
    end
  endtask

  task automatic test_bad_chk();
    frm = '{8'hA5, 8'h10, 8'h00, 8'h00, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'hDB};
    send_frame(0);
    idle(2);
    checks++;
    if ({got_q.size(), done_cnt, load_error, core_reset} !== {32'd2, 32'd0, 1'b1, 1'b1}) begin
      errors++; $display("FAIL badchk_status got wr=%0d done=%0d err=%b cr=%b exp 2/0/1/1", got_q.size(), done_cnt, load_error, core_reset);
    end
    frm[10] = 8'hDA;
    got_q.delete(); done_cnt = 0;
    send_byte(frm[0]);
    checks++;
    if ({load_error, core_reset, word_count} !== {1'b0, 1'b1, 16'd0}) begin
      errors++; $display("FAIL sync_clears_err got err=%b cr=%b wc=%0d exp 0/1/0", load_error, core_reset, word_count);
    end
    for (int i = 1; i < frm.size(); i++) send_byte(frm[i]);
    idle(2);
    checks++;
    if ({got_q.size(), done_cnt, load_error, core_reset} !== {32'd2, 32'd1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL good_after_bad got wr=%0d done=%0d err=%b cr=%b exp 2/1/0/0", got_q.size(), done_cnt, load_error, core_reset);
    end
  endtask

  task automatic test_wrap();
    frm = '{8'hA5, 8'hFF, 8'hFF, 8'h0F, 8'h02, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'hEE};
    exp_q = '{{20'hFFFFF, 16'h0001}, {20'h00000, 16'h0002}};
    send_frame(2);
    idle(2);
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL wrap_nwrites got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL wrap_write%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL wrap_done got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_zero_count();
    frm = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(0);
    checks++;
    if (load_done !== 1'b1) begin errors++; $display("FAIL zero_done_next got=%b exp=1", load_done); end
    idle(2);
    checks++;
    if ({got_q.size(), done_cnt, word_count, core_reset} !== {32'd0, 32'd1, 16'd0, 1'b0}) begin
      errors++; $display("FAIL zero_status got wr=%0d done=%0d wc=%0d cr=%b exp 0/1/0/0", got_q.size(), done_cnt, word_count, core_reset);
    end
  endtask

  task automatic test_timeout();
    frm = '{8'hA5, 8'h10};
    send_frame(0);
    idle(15);
    checks++;
    if (load_error !== 1'b0) begin errors++; $display("FAIL timeout_early got=%b exp=0", load_error); end
    idle(1);
    checks++;
    if ({load_error, core_reset} !== 2'b11) begin errors++; $display("FAIL timeout_hit got err=%b cr=%b exp 1/1", load_error, core_reset); end
    frm = '{8'h10, 8'h00, 8'hA5, 8'h10, 8'h00, 8'h00, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'hDA};
    exp_q = '{{20'h00010, 16'h1234}, {20'h00011, 16'h5678}};
    send_frame(0);
    idle(2);
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL post_timeout_nwrites got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL post_timeout_write%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++;
    if ({done_cnt, load_error} !== {32'd1, 1'b0}) begin errors++; $display("FAIL post_timeout_done got done=%0d err=%b exp 1/0", done_cnt, load_error); end
  endtask

  task automatic test_reset_mid();
    frm = '{8'hA5, 8'h10, 8'h00, 8'h00, 8'h02, 8'h00, 8'h34};
    send_frame(0);
    reset = 1'b1;
    idle(1);
    checks++;
    if ({rx_ready, instruction_wr, instruction_wr_data, instruction_wr_enable} !== 38'd0) begin
      errors++; $display("FAIL midreset_wr got rdy=%b %h/%h/%b exp all 0", rx_ready, instruction_wr, instruction_wr_data, instruction_wr_enable);
    end
    checks++;
    if ({core_reset, load_done, load_error, word_count} !== {1'b1, 1'b0, 1'b0, 16'd0}) begin
      errors++; $display("FAIL midreset_status got cr=%b done=%b err=%b wc=%0d exp 1/0/0/0", core_reset, load_done, load_error, word_count);
    end
    reset = 1'b0;
    idle(3);
    checks++;
    if (got_q.size() != 0) begin errors++; $display("FAIL midreset_nowrite got=%0d exp=0", got_q.size()); end
    make_rand_frame(1'b1);
    model();
    send_frame(3);
    idle(2);
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL reload_nwrites got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL reload_write%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++;
    if ({done_cnt, core_reset} !== {32'd1, 1'b0}) begin errors++; $display("FAIL reload_done got done=%0d cr=%b exp 1/0", done_cnt, core_reset); end
  endtask

  task automatic test_random();
    logic [7:0] junk;
    for (int f = 0; f < 12; f++) begin
      repeat ($urandom_range(2, 0)) begin
        junk = 8'($urandom_range(255, 0));
        if (junk == 8'hA5) junk = 8'h00;
        send_byte(junk);
      end
      make_rand_frame($urandom_range(3, 0) != 0);
      model();
      send_frame(3);
      idle(2);
      checks++;
      if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand%0d_nwrites got=%0d exp=%0d", f, got_q.size(), exp_q.size()); end
      else foreach (exp_q[i]) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_write%0d got=%h exp=%h", f, i, got_q[i], exp_q[i]); end
      end
      checks++;
      if ({done_cnt, load_error, core_reset, word_count, pulse_bad} !==
          {32'(exp_good), !exp_good, !exp_good, 16'(exp_n), 32'd0}) begin
        errors++;
        $display("FAIL rand%0d_status got done=%0d err=%b cr=%b wc=%0d pb=%0d exp done=%0d err=%b wc=%0d",
                 f, done_cnt, load_error, core_reset, word_count, pulse_bad, exp_good, !exp_good, exp_n);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_chk();
    test_wrap();
    test_zero_count();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
